decode_exec_pipe_reg: RTL and testbench

Parametrised decode/execute pipeline register: successor to the fixed-width, stall-less ID/EX latch. Adds a valid bit, external stall, flush, and a configurable immediate delay line that feeds the execute stage's late immediate path. It also detects load-use hazards, inserting a bubble and back-pressuring fetch/decode. Sits between the decoder and the ALU/execute stage of the pipelined RV core.

---
 rtl/decode_exec_pipe_reg.sv | 110 +++++++++++
 tb/tb_decode_exec_pipe_reg.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_pipe_reg.sv
// decode_exec_pipe_reg
// Decode/execute pipeline register with valid bit, external stall, flush and
// a configurable delay line on the immediate path feeding the late-immediate
// input of execute.
// Optional feature macro: DECODE_HAZARD_EN enables load-use detection,
// bubble insertion, hazard_stall and the saturating bubble counter. With it
// undefined, hazard_stall and bubble_count are tied to 0.
module decode_exec_pipe_reg #(
  parameter int WIDTH     = 15,
  parameter int IMM_DELAY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [4:0]       r_reg1,
  input  logic [4:0]       r_reg2,
  input  logic [4:0]       wr_reg,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] immediate_data,
  output logic             out_valid,
  output logic [4:0]       r_reg1_out,
  output logic [4:0]       r_reg2_out,
  output logic [4:0]       wr_reg_out,
  output logic [2:0]       func3_out,
  output logic [6:0]       func7_out,
  output logic [6:0]       opcode_out,
  output logic [WIDTH-1:0] immediate_data_out,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_count
);

  logic             hazard;
  logic [WIDTH-1:0] imm_chain [IMM_DELAY];

`ifdef DECODE_HAZARD_EN
  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  // Load in execute whose destination is read by the valid instruction in decode.
  // Uses only registered outputs and current inputs, so no combinational loop.
  assign hazard = out_valid && (opcode_out == OPC_LOAD) && (wr_reg_out != 5'd0) &&
                  in_valid && ((r_reg1 == wr_reg_out) || (r_reg2 == wr_reg_out));
`else
  assign hazard = 1'b0;
`endif

  // flush and stall_in both outrank the hazard; in reset out_valid=0 keeps this low.
  assign hazard_stall = hazard && !flush && !stall_in;

  // Field register: flush or bubble clears, stall holds, otherwise capture decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      r_reg1_out <= '0;
      r_reg2_out <= '0;
      wr_reg_out <= '0;
      func3_out  <= '0;
      func7_out  <= '0;
      opcode_out <= '0;
    end else if (flush || hazard_stall) begin
      out_valid  <= 1'b0;
      r_reg1_out <= '0;
      r_reg2_out <= '0;
      wr_reg_out <= '0;
      func3_out  <= '0;
      func7_out  <= '0;
      opcode_out <= '0;
    end else if (!stall_in) begin
      out_valid  <= in_valid;
      r_reg1_out <= r_reg1;
      r_reg2_out <= r_reg2;
      wr_reg_out <= wr_reg;
      func3_out  <= func3;
      func7_out  <= func7;
      opcode_out <= opcode;
    end
  end

  // Immediate delay line: shifts on advance and bubble edges (a bubble feeds 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < IMM_DELAY; i++) imm_chain[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < IMM_DELAY; i++) imm_chain[i] <= '0;
    end else if (!stall_in) begin
      imm_chain[0] <= hazard_stall ? '0 : immediate_data;
      for (int i = 1; i < IMM_DELAY; i++) imm_chain[i] <= imm_chain[i-1];
    end
  end

  assign immediate_data_out = imm_chain[IMM_DELAY-1];

`ifdef DECODE_HAZARD_EN
  // Saturating count of inserted bubbles; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_count <= '0;
    end else if (hazard_stall && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end
`else
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_decode_exec_pipe_reg.sv
// Testbench for decode_exec_pipe_reg: directed scenarios plus randomized
// traffic, checked against a queue-based reference model through a scoreboard.
module tb_decode_exec_pipe_reg;

`ifdef DECODE_HAZARD_EN
  localparam bit HAZ_EN = 1'b1;
`else
  localparam bit HAZ_EN = 1'b0;
`endif
  localparam int IMM_DELAY = 2;

  typedef struct {
    logic        v;
    logic [4:0]  r1, r2, wr;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [14:0] imm;
    logic        st, fl;
  } in_t;

  typedef struct {
    logic        v;
    logic [4:0]  r1, r2, wr;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [14:0] imm;
    logic        haz;
    logic [15:0] bub;
    logic [1:0]  bs;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in, flush, in_valid;
  logic [4:0]  r_reg1, r_reg2, wr_reg;
  logic [2:0]  func3;
  logic [6:0]  func7, opcode;
  logic [14:0] immediate_data;
  logic        out_valid, hazard_stall;
  logic [4:0]  r_reg1_out, r_reg2_out, wr_reg_out;
  logic [2:0]  func3_out;
  logic [6:0]  func7_out, opcode_out;
  logic [14:0] immediate_data_out;
  logic [15:0] bubble_count;

  logic        s_out_valid, s_hazard_stall;
  logic [4:0]  s_r_reg1_out, s_r_reg2_out, s_wr_reg_out;
  logic [2:0]  s_func3_out;
  logic [6:0]  s_func7_out, s_opcode_out;
  logic [14:0] s_immediate_data_out;
  logic [1:0]  s_bubble_count;

  int checks = 0;
  int errors = 0;

  rec_t sb_q[$];
  event mon_kick;

  // reference model state
  in_t        m;
  logic [14:0] imm_q[$];
  int          bub;

  always #5 clk = ~clk;

  decode_exec_pipe_reg #(.WIDTH(15), .IMM_DELAY(IMM_DELAY), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush), .in_valid(in_valid),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .wr_reg(wr_reg), .func3(func3), .func7(func7),
    .opcode(opcode), .immediate_data(immediate_data), .out_valid(out_valid),
    .r_reg1_out(r_reg1_out), .r_reg2_out(r_reg2_out), .wr_reg_out(wr_reg_out),
    .func3_out(func3_out), .func7_out(func7_out), .opcode_out(opcode_out),
    .immediate_data_out(immediate_data_out), .hazard_stall(hazard_stall),
    .bubble_count(bubble_count)
  );

  decode_exec_pipe_reg #(.WIDTH(15), .IMM_DELAY(IMM_DELAY), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .flush(flush), .in_valid(in_valid),
    .r_reg1(r_reg1), .r_reg2(r_reg2), .wr_reg(wr_reg), .func3(func3), .func7(func7),
    .opcode(opcode), .immediate_data(immediate_data), .out_valid(s_out_valid),
    .r_reg1_out(s_r_reg1_out), .r_reg2_out(s_r_reg2_out), .wr_reg_out(s_wr_reg_out),
    .func3_out(s_func3_out), .func7_out(s_func7_out), .opcode_out(s_opcode_out),
    .immediate_data_out(s_immediate_data_out), .hazard_stall(s_hazard_stall),
    .bubble_count(s_bubble_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic in_t mk(input logic v, input logic [6:0] op, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] wr, input logic [14:0] imm);
    in_t i;
    i.v = v; i.op = op; i.r1 = r1; i.r2 = r2; i.wr = wr; i.imm = imm;
    i.f3 = 3'd2; i.f7 = 7'h20; i.st = 1'b0; i.fl = 1'b0;
    return i;
  endfunction

  task automatic model_reset();
    m = mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 15'd0);
    m.f3 = 3'd0; m.f7 = 7'd0;
    imm_q.delete();
    for (int k = 0; k < IMM_DELAY; k++) imm_q.push_back(15'd0);
    bub = 0;
  endtask

  // load in execute, its destination read by a valid decode instruction
  function automatic logic model_haz(input in_t i);
    return HAZ_EN && m.v && (m.op == 7'h03) && (m.wr != 5'd0) && i.v &&
           ((i.r1 == m.wr) || (i.r2 == m.wr)) && !i.fl && !i.st;
  endfunction

  task automatic model_edge(input in_t i);
    if (i.fl) begin
      m = mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 15'd0);
      m.f3 = 3'd0; m.f7 = 7'd0;
      foreach (imm_q[k]) imm_q[k] = 15'd0;
    end else if (i.st) begin
      // everything holds
    end else if (model_haz(i)) begin
      m = mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 15'd0);
      m.f3 = 3'd0; m.f7 = 7'd0;
      imm_q.push_front(15'd0);
      void'(imm_q.pop_back());
      bub++;
    end else begin
      m = i;
      imm_q.push_front(i.imm);
      void'(imm_q.pop_back());
    end
  endtask

  function automatic rec_t expect_now(input in_t i);
    rec_t r;
    r.v = m.v; r.r1 = m.r1; r.r2 = m.r2; r.wr = m.wr;
    r.f3 = m.f3; r.f7 = m.f7; r.op = m.op;
    r.imm = imm_q[IMM_DELAY-1];
    r.haz = model_haz(i);
    r.bub = 16'((bub > 65535) ? 65535 : bub);
    r.bs  = 2'((bub > 3) ? 3 : bub);
    return r;
  endfunction

  task automatic apply(input in_t i);
    in_valid = i.v; r_reg1 = i.r1; r_reg2 = i.r2; wr_reg = i.wr;
    func3 = i.f3; func7 = i.f7; opcode = i.op; immediate_data = i.imm;
    stall_in = i.st; flush = i.fl;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic cycle(input in_t i);
    apply(i);
    sb_q.push_back(expect_now(i));
    @(posedge clk);
    model_edge(i);
    #1;
  endtask

  // Reset asserted between edges while a load-use hazard is being presented.
  task automatic async_reset_mid(input in_t i);
    apply(i);
    sb_q.push_back(expect_now(i));
    #1 -> mon_kick;
    #1 rst_n = 1'b0;
    model_reset();
    sb_q.push_back(expect_now(i));
    #1 -> mon_kick;
    #3 rst_n = 1'b1;
    @(posedge clk);
    model_edge(i);
    #1;
  endtask

  function automatic in_t rand_in();
    in_t i;
    i.v   = ($urandom_range(0, 3) != 0);
    i.r1  = 5'($urandom_range(0, 3));
    i.r2  = 5'($urandom_range(0, 3));
    i.wr  = 5'($urandom_range(0, 3));
    i.op  = ($urandom_range(0, 1) == 0) ? 7'h03 : 7'($urandom);
    i.f3  = 3'($urandom);
    i.f7  = 7'($urandom);
    i.imm = 15'($urandom);
    i.st  = ($urandom_range(0, 6) == 0);
    i.fl  = ($urandom_range(0, 11) == 0);
    return i;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    rec_t r;
    forever begin
      @(negedge clk or mon_kick);
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        chk("out_valid",    32'(out_valid),          32'(r.v));
        chk("r_reg1_out",   32'(r_reg1_out),         32'(r.r1));
        chk("r_reg2_out",   32'(r_reg2_out),         32'(r.r2));
        chk("wr_reg_out",   32'(wr_reg_out),         32'(r.wr));
        chk("func3_out",    32'(func3_out),          32'(r.f3));
        chk("func7_out",    32'(func7_out),          32'(r.f7));
        chk("opcode_out",   32'(opcode_out),         32'(r.op));
        chk("imm_out",      32'(immediate_data_out), 32'(r.imm));
        chk("hazard_stall", 32'(hazard_stall),       32'(r.haz));
        chk("bubble_count", 32'(bubble_count),       32'(HAZ_EN ? r.bub : 16'd0));
        chk("sat_bubble_count", 32'(s_bubble_count), 32'(HAZ_EN ? r.bs : 2'd0));
        chk("sat_imm_out",  32'(s_immediate_data_out), 32'(r.imm));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    in_t i;
    rst_n = 1'b0;
    model_reset();
    apply(mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 15'd0));
    stall_in = 1'b0; flush = 1'b0; func3 = 3'd0; func7 = 7'd0;
    sb_q.push_back(expect_now(mk(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 15'd0)));
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic advance: fields after 1 edge, immediate after 2
    cycle(mk(1'b1, 7'h33, 5'd3, 5'd4, 5'd5, 15'h1234));
    cycle(mk(1'b0, 7'h13, 5'd0, 5'd0, 5'd0, 15'h0abc));
    cycle(mk(1'b0, 7'h13, 5'd0, 5'd0, 5'd0, 15'h0001));

    // load-use on r_reg2: one bubble, then the dependent instruction
    cycle(mk(1'b1, 7'h03, 5'd1, 5'd2, 5'd7, 15'h0111));
    cycle(mk(1'b1, 7'h33, 5'd6, 5'd7, 5'd8, 15'h0222));
    cycle(mk(1'b1, 7'h33, 5'd6, 5'd7, 5'd8, 15'h0222));
    cycle(mk(1'b1, 7'h33, 5'd1, 5'd1, 5'd9, 15'h0333));

    // load to x0 and load with no matching source: no bubble
    cycle(mk(1'b1, 7'h03, 5'd1, 5'd2, 5'd0, 15'h0444));
    cycle(mk(1'b1, 7'h33, 5'd0, 5'd0, 5'd3, 15'h0555));
    cycle(mk(1'b1, 7'h03, 5'd1, 5'd2, 5'd9, 15'h0666));
    cycle(mk(1'b1, 7'h33, 5'd8, 5'd10, 5'd3, 15'h0777));

    // stall for 3 cycles mid-stream, then resume
    cycle(mk(1'b1, 7'h33, 5'd1, 5'd2, 5'd3, 15'h1001));
    cycle(mk(1'b1, 7'h13, 5'd4, 5'd5, 5'd6, 15'h1002));
    for (int k = 0; k < 3; k++) begin
      i = rand_in(); i.st = 1'b1; i.fl = 1'b0;
      cycle(i);
    end
    cycle(mk(1'b1, 7'h13, 5'd4, 5'd5, 5'd6, 15'h1002));
    cycle(mk(1'b1, 7'h33, 5'd7, 5'd8, 5'd9, 15'h1003));
    cycle(mk(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 15'h1004));

    // flush and stall together while out_valid=1
    cycle(mk(1'b1, 7'h33, 5'd1, 5'd2, 5'd3, 15'h2001));
    i = mk(1'b1, 7'h33, 5'd4, 5'd5, 5'd6, 15'h2002); i.st = 1'b1; i.fl = 1'b1;
    cycle(i);
    cycle(mk(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 15'h2003));
    cycle(mk(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 15'h2004));

    // flush coinciding with a hazard: no bubble counted
    cycle(mk(1'b1, 7'h03, 5'd1, 5'd2, 5'd5, 15'h2100));
    i = mk(1'b1, 7'h33, 5'd5, 5'd0, 5'd6, 15'h2101); i.fl = 1'b1;
    cycle(i);

    // saturation of the 2-bit counter: five load-use pairs
    for (int k = 0; k < 5; k++) begin
      cycle(mk(1'b1, 7'h03, 5'd0, 5'd0, 5'd11, 15'(16'h3000 + k)));
      cycle(mk(1'b1, 7'h33, 5'd11, 5'd1, 5'd2, 15'h3100));
      cycle(mk(1'b1, 7'h33, 5'd11, 5'd1, 5'd2, 15'h3100));
    end

    // asynchronous reset while a hazard is presented
    cycle(mk(1'b1, 7'h03, 5'd0, 5'd0, 5'd12, 15'h4000));
    async_reset_mid(mk(1'b1, 7'h33, 5'd12, 5'd3, 5'd4, 15'h4001));
    cycle(mk(1'b1, 7'h33, 5'd1, 5'd2, 5'd3, 15'h4002));
    cycle(mk(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 15'h4003));

    // randomized traffic
    for (int k = 0; k < 400; k++) cycle(rand_in());

    cycle(mk(1'b0, 7'h00, 5'd0, 5'd0, 5'd0, 15'h0000));
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
